lu_decomp: RTL



---
 rtl/lu_decomp_pkg.sv | 20 ++
 rtl/lu_decomp_if.sv | 22 ++
 rtl/lu_decomp_pivot_div.sv | 31 +++
 rtl/lu_decomp.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lu_decomp_pkg.sv
// Shared matrix constants, FSM state type and packing helper for the LU,
// forward-substitution and backward-substitution stages.
package matrix_pkg;

  localparam int N = 4;
  localparam int W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FACTOR,
    S_UPDATE,
    S_DONE
  } lu_state_t;

  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

endpackage

// File: rtl/lu_decomp_if.sv
// Start/result bundle of the LU engine; master drives the request, slave is the engine.
interface lu_decomp_if;
  import matrix_pkg::*;

  logic               start;
  logic [N*N*W-1:0]   A_in;
  logic               done;
  logic [N*N*W-1:0]   L_out;
  logic [N*N*W-1:0]   U_out;
  logic               singular;

  modport master (
    output start, A_in,
    input  done, L_out, U_out, singular
  );

  modport slave (
    input  start, A_in,
    output done, L_out, U_out, singular
  );

endinterface

// File: rtl/lu_decomp_pivot_div.sv
// Combinational guarded signed divider producing the elimination factor f.
module lu_pivot_div
  import matrix_pkg::*;
#(
  parameter int FRAC = 0
) (
  input  logic signed [W-1:0] i_num,
  input  logic signed [W-1:0] i_piv,
  output logic signed [W-1:0] o_f,
  output logic                o_zero
);

  logic signed [W-1:0] w_num_sh;

  assign w_num_sh = i_num <<< FRAC;
  assign o_zero   = (i_piv == '0);

  // A pivot of -1 is handled as negation so the most negative numerator wraps
  // instead of overflowing the divider.
  always_comb begin
    o_f = '0;
    if (o_zero) begin
      o_f = '0;
    end else if (&i_piv) begin
      o_f = -w_num_sh;
    end else begin
      o_f = w_num_sh / i_piv;
    end
  end

endmodule

// File: rtl/lu_decomp.sv
// 4x4 in-place LU factorisation (no pivoting), one row update every two cycles.
// Optional macro LU_SINGULAR_DETECT_EN builds the zero-pivot singular flag.
module lu_decomp
  import matrix_pkg::*;
#(
  parameter int FRAC = 0
) (
  input logic        clk,
  input logic        rst,
  lu_decomp_if.slave bus
);

  lu_state_t           r_state;
  lu_state_t           w_state_nxt;

  logic signed [W-1:0] r_a [N*N];
  logic signed [W-1:0] r_l [N*N];
  logic signed [W-1:0] w_a_upd [N*N];
  logic signed [W-1:0] r_f;
  logic [1:0]          r_k;
  logic [1:0]          r_i;
  logic                r_done;
  logic [N*N*W-1:0]    r_L;
  logic [N*N*W-1:0]    r_U;

  logic signed [W-1:0] w_piv;
  logic signed [W-1:0] w_num;
  logic signed [W-1:0] w_f;
  logic                w_zero;
  logic                w_last;

  function automatic logic signed [W-1:0] mul_shift(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    p = p >>> FRAC;
    return p[W-1:0];
  endfunction

  assign w_piv  = r_a[{r_k, r_k}];
  assign w_num  = r_a[{r_i, r_k}];
  assign w_last = (r_i == 2'd3) && (r_k == 2'd2);

  lu_pivot_div #(
    .FRAC (FRAC)
  ) u_div (
    .i_num  (w_num),
    .i_piv  (w_piv),
    .o_f    (w_f),
    .o_zero (w_zero)
  );

  // Row i minus f times pivot row k, all columns from k onward at once.
  always_comb begin
    w_a_upd = r_a;
    for (int j = 0; j < N; j++) begin
      if (2'(j) >= r_k) begin
        w_a_upd[{r_i, 2'(j)}] = r_a[{r_i, 2'(j)}] - mul_shift(r_f, r_a[{r_k, 2'(j)}]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_FACTOR;
      S_FACTOR: w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_last ? S_DONE : S_FACTOR;
      S_DONE:   if (!bus.start) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N*N; n++) begin
        r_a[4'(n)] <= '0;
        r_l[4'(n)] <= '0;
      end
      r_f    <= '0;
      r_k    <= '0;
      r_i    <= '0;
      r_done <= 1'b0;
      r_L    <= '0;
      r_U    <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          for (int n = 0; n < N*N; n++) begin
            r_a[4'(n)] <= bus.A_in[n*W +: W];
            r_l[4'(n)] <= (n % (N+1) == 0) ? W'(1) : '0;
          end
          r_k <= 2'd0;
          r_i <= 2'd1;
        end
        S_FACTOR: begin
          r_f             <= w_f;
          r_l[{r_i, r_k}] <= w_f;
        end
        S_UPDATE: begin
          r_a <= w_a_upd;
          if (r_i != 2'd3) begin
            r_i <= r_i + 2'd1;
          end else if (r_k != 2'd2) begin
            r_k <= r_k + 2'd1;
            r_i <= r_k + 2'd2;
          end
          // Results are published from the post-update array on the final edge.
          if (w_last) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                r_L[idx(r, c)*W +: W] <= r_l[4'(idx(r, c))];
                r_U[idx(r, c)*W +: W] <= (r > c) ? '0 : w_a_upd[4'(idx(r, c))];
              end
            end
            r_done <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.start) r_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LU_SINGULAR_DETECT_EN
  logic r_sing;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sing <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_sing <= 1'b0;
    end else if (r_state == S_FACTOR && w_zero) begin
      r_sing <= 1'b1;
    end
  end

  assign bus.singular = r_sing;
`else
  logic w_unused_zero;
  assign w_unused_zero = w_zero;
  assign bus.singular  = 1'b0;
`endif

  assign bus.done  = r_done;
  assign bus.L_out = r_L;
  assign bus.U_out = r_U;

endmodule
